// File: rtl/merge_feeder_if.sv
// Handshake and frame bus between the element source and merge_feeder.
// The slave modport is the feeder side; the master modport is the source/sink side.
interface merge_feeder_if #(
  parameter int WIDTH = 3,
  parameter int n     = 16
);
  logic                     in_valid;
  logic [WIDTH-1:0]         in_data;
  logic                     in_ready;
  logic [2*n*WIDTH-1:0]     inba;
  logic [1:0]               load;
  logic                     frame_valid;
  logic                     frame_ack;
  logic                     order_err;

  modport slave (
    input  in_valid, in_data, frame_ack,
    output in_ready, inba, load, frame_valid, order_err
  );

  modport master (
    output in_valid, in_data, frame_ack,
    input  in_ready, inba, load, frame_valid, order_err
  );
endinterface

// File: rtl/merge_feeder.sv
// Collects two n-element halves into one packed frame for a downstream merger,
// strobing each completed half and flagging halves that are not non-decreasing.
module merge_feeder #(
  parameter int WIDTH = 3,
  parameter int n     = 16
) (
  input  logic          clk,
  input  logic          rst,
  merge_feeder_if.slave bus
);
  localparam int CW = $clog2(n);

  typedef enum logic [1:0] {
    FILL_A = 2'd0,
    FILL_B = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CW-1:0]        r_cnt;
  logic [WIDTH-1:0]     r_last;
  logic [2*n*WIDTH-1:0] r_inba;
  logic [1:0]           r_load;
  logic [1:0]           w_load_nxt;
  logic                 r_frame_valid;
  logic                 w_fv_nxt;
  logic                 r_order_err;
  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_last_slot;
  logic                 w_ack;
  logic                 w_order_viol;
  logic [CW:0]          w_slot_idx;

  assign w_in_ready   = (r_state == FILL_A) || (r_state == FILL_B);
  assign w_accept     = bus.in_valid && w_in_ready;
  assign w_last_slot  = (r_cnt == CW'(n - 1));
  assign w_ack        = (r_state == DONE) && bus.frame_ack;
  // Upper index bit selects the half, so half B lands above half A.
  assign w_slot_idx   = {(r_state == FILL_B), r_cnt};
  // Slot 0 of either half is never compared, so the A/B boundary is exempt.
  assign w_order_viol = w_accept && (r_cnt != {CW{1'b0}}) && (bus.in_data < r_last);
  assign w_fv_nxt     = (w_state_nxt == DONE);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= FILL_A;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and half-complete strobe decode.
  always_comb begin
    w_state_nxt = r_state;
    w_load_nxt  = 2'b00;
    case (r_state)
      FILL_A: begin
        if (w_accept && w_last_slot) begin
          w_state_nxt = FILL_B;
          w_load_nxt  = 2'b01;
        end else begin
          w_state_nxt = FILL_A;
        end
      end
      FILL_B: begin
        if (w_accept && w_last_slot) begin
          w_state_nxt = DONE;
          w_load_nxt  = 2'b10;
        end else begin
          w_state_nxt = FILL_B;
        end
      end
      DONE: begin
        if (bus.frame_ack) begin
          w_state_nxt = FILL_A;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = FILL_A;
        w_load_nxt  = 2'b00;
      end
    endcase
  end

  // Slot counter, frame storage, ordering check and registered strobes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt         <= {CW{1'b0}};
      r_last        <= {WIDTH{1'b0}};
      r_inba        <= {(2*n*WIDTH){1'b0}};
      r_load        <= 2'b00;
      r_frame_valid <= 1'b0;
      r_order_err   <= 1'b0;
    end else begin
      r_load        <= w_load_nxt;
      r_frame_valid <= w_fv_nxt;
      if (w_accept) begin
        r_cnt  <= r_cnt + CW'(1);
        r_last <= bus.in_data;
        r_inba[int'(w_slot_idx)*WIDTH +: WIDTH] <= bus.in_data;
      end else if (w_ack) begin
        r_cnt <= {CW{1'b0}};
      end
      if (w_ack) begin
        r_order_err <= 1'b0;
      end else if (w_order_viol) begin
        r_order_err <= 1'b1;
      end
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.inba        = r_inba;
  assign bus.load        = r_load;
  assign bus.frame_valid = r_frame_valid;
  assign bus.order_err   = r_order_err;
endmodule

// File: tb/tb_merge_feeder.sv
// Randomized bench for merge_feeder: a frame-level reference model predicts
// packed contents, strobe timing and the ordering flag from the element list.
module tb_merge_feeder;
  localparam int W = 3;
  localparam int N = 16;

  logic clk;
  logic rst;
  merge_feeder_if #(.WIDTH(W), .n(N)) bus ();

  merge_feeder #(.WIDTH(W), .n(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [W-1:0]       elems [2*N];
  logic [2*N*W-1:0]   exp_inba;

  // Reference rule: a half is bad if any later element is smaller than its predecessor.
  function automatic logic frame_err();
    logic e = 1'b0;
    for (int h = 0; h < 2; h++)
      for (int k = 1; k < N; k++)
        if (elems[h*N+k] < elems[h*N+k-1]) e = 1'b1;
    return e;
  endfunction

  task automatic fill_sorted();
    for (int i = 0; i < 2*N; i++) elems[i] = W'((i % N) >> 1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 2*N; i++) elems[i] = W'($urandom);
  endtask

  // mode 0: valid always high, 1: toggling, 2: random valid plus stray frame_ack.
  task automatic feed_frame(input int mode, input int limit);
    int acc = 0;
    int cyc = 0;
    logic v;
    logic [1:0] exp_load;
    while (acc < limit && cyc < 400) begin
      v = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
      bus.in_valid  = v;
      bus.in_data   = v ? elems[acc] : W'($urandom);
      bus.frame_ack = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (bus.in_ready !== 1'b1) $display("FAIL in_ready_fill: got %b want 1 (acc %0d)", bus.in_ready, acc);
      else pass_cnt++;
      chk_cnt++;
      @(posedge clk);
      exp_load = 2'b00;
      if (v) begin
        exp_inba[acc*W +: W] = elems[acc];
        acc++;
        if (acc == N) exp_load = 2'b01;
        if (acc == 2*N) exp_load = 2'b10;
      end
      @(negedge clk);
      if (bus.load !== exp_load) $display("FAIL load: got %b want %b (acc %0d)", bus.load, exp_load, acc);
      else pass_cnt++;
      chk_cnt++;
      if (bus.frame_valid !== (acc == 2*N)) $display("FAIL frame_valid_fill: got %b want %b", bus.frame_valid, (acc == 2*N));
      else pass_cnt++;
      chk_cnt++;
      if (bus.inba !== exp_inba) $display("FAIL inba_fill: got %h want %h (acc %0d)", bus.inba, exp_inba, acc);
      else pass_cnt++;
      chk_cnt++;
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.frame_ack = 1'b0;
    if (acc < limit) begin
      $display("FAIL feed_timeout: got %0d acceptances want %0d", acc, limit);
      chk_cnt++;
    end else if (limit == 2*N) begin
      if (bus.order_err !== frame_err()) $display("FAIL order_err_frame: got %b want %b", bus.order_err, frame_err());
      else pass_cnt++;
      chk_cnt++;
    end
  endtask

  task automatic do_ack();
    bus.frame_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.frame_ack = 1'b0;
    if (bus.frame_valid !== 1'b0 || bus.order_err !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL ack: got fv=%b oe=%b rdy=%b want 0 0 1", bus.frame_valid, bus.order_err, bus.in_ready);
    else pass_cnt++;
    chk_cnt++;
    if (bus.inba !== exp_inba) $display("FAIL inba_ack: got %h want %h", bus.inba, exp_inba);
    else pass_cnt++;
    chk_cnt++;
  endtask

  task automatic check_reset_vals(input string tag);
    if (bus.in_ready !== 1'b1 || bus.load !== 2'b00 || bus.frame_valid !== 1'b0 || bus.order_err !== 1'b0)
      $display("FAIL %s: got rdy=%b load=%b fv=%b oe=%b want 1 00 0 0", tag, bus.in_ready, bus.load, bus.frame_valid, bus.order_err);
    else pass_cnt++;
    chk_cnt++;
    if (bus.inba !== '0) $display("FAIL %s_inba: got %h want 0", tag, bus.inba);
    else pass_cnt++;
    chk_cnt++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.frame_ack = 1'b0;
    exp_inba = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b1;
  endtask

  task automatic test_sorted_stream();
    fill_sorted();
    feed_frame(0, 2*N);
    do_ack();
  endtask

  task automatic test_toggle_stream();
    fill_sorted();
    feed_frame(1, 2*N);
    do_ack();
  endtask

  task automatic test_order_err();
    fill_sorted();
    elems[N+6] = W'(5);
    elems[N+7] = W'(3);
    feed_frame(0, 2*N);
    if (bus.order_err !== 1'b1) $display("FAIL order_err_set: got %b want 1", bus.order_err);
    else pass_cnt++;
    chk_cnt++;
    do_ack();
  endtask

  task automatic test_boundary();
    fill_sorted();
    for (int k = 0; k < N; k++) elems[k] = (k < N/2) ? W'(k >> 1) : W'(7);
    elems[N] = W'(0);
    feed_frame(2, 2*N);
    if (bus.order_err !== 1'b0) $display("FAIL boundary_err: got %b want 0", bus.order_err);
    else pass_cnt++;
    chk_cnt++;
    do_ack();
  endtask

  task automatic test_done_hold();
    fill_random();
    feed_frame(0, 2*N);
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = W'($urandom);
      @(posedge clk);
      @(negedge clk);
      if (bus.in_ready !== 1'b0 || bus.frame_valid !== 1'b1 || bus.inba !== exp_inba)
        $display("FAIL done_hold: got rdy=%b fv=%b inba=%h want 0 1 %h", bus.in_ready, bus.frame_valid, bus.inba, exp_inba);
      else pass_cnt++;
      chk_cnt++;
    end
    bus.in_valid = 1'b0;
    do_ack();
    fill_random();
    feed_frame(2, 2*N);
    do_ack();
  endtask

  task automatic test_reset_mid();
    fill_random();
    feed_frame(0, 20);
    rst = 1'b0;
    exp_inba = '0;
    #1;
    check_reset_vals("reset_mid_now");
    repeat (2) @(negedge clk);
    check_reset_vals("reset_mid_hold");
    rst = 1'b1;
    fill_random();
    feed_frame(0, 2*N);
    do_ack();
  endtask

  task automatic test_random_frames();
    for (int f = 0; f < 4; f++) begin
      if (f % 2 == 0) fill_random(); else fill_sorted();
      feed_frame(2, 2*N);
      do_ack();
    end
  endtask

  initial begin
    test_reset();
    test_sorted_stream();
    test_toggle_stream();
    test_order_err();
    test_boundary();
    test_done_hold();
    test_reset_mid();
    test_random_frames();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
